// File: rtl/imem_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words, writes them
// sequentially into instruction memory, then raises the CPU start. Optional checksum phase: IMEM_LOADER_CKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              busy_o,
  output logic              start_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE, RECV, WRITE, DONE
`ifdef IMEM_LOADER_CKSUM_EN
    , CKSUM
`endif
  } state_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   addr_q, len_q;
  logic [1:0]        idx_q;
  logic [23:0]       part_q;
  logic              load_ok, len_zero, len_bad, hs, lane3, last_word;
  logic [31:0]       word_in;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0]       sum_q;
  logic              sum_ok;
`endif

  assign load_ok   = load_i && (state_q == IDLE || state_q == DONE);
  assign len_zero  = (len_i == '0);
  // Anything above 2^ADDR_W has the top bit set plus at least one lower bit.
  assign len_bad   = len_i[ADDR_W] && (|len_i[ADDR_W-1:0]);
  assign hs        = byte_valid_i && byte_ready_o;
  assign lane3     = (idx_q == 2'd3);
  assign word_in   = {byte_data_i, part_q};
  assign last_word = ((addr_q + ONE) == len_q);
`ifdef IMEM_LOADER_CKSUM_EN
  assign sum_ok    = (word_in == sum_q);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (load_ok) begin
          if (len_zero)     state_d = DONE;
          else if (len_bad) state_d = IDLE;
          else              state_d = RECV;
        end
      end
      RECV:  if (hs && lane3) state_d = WRITE;
      WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_d = CKSUM;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = RECV;
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      CKSUM: if (hs && lane3) state_d = sum_ok ? DONE : IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byte_ready_o <= 1'b0;
      imem_we_o    <= 1'b0;
      busy_o       <= 1'b0;
      start_o      <= 1'b0;
      err_o        <= 1'b0;
    end else begin
`ifdef IMEM_LOADER_CKSUM_EN
      byte_ready_o <= (state_d == RECV) || (state_d == CKSUM);
      busy_o       <= (state_d == RECV) || (state_d == WRITE) || (state_d == CKSUM);
`else
      byte_ready_o <= (state_d == RECV);
      busy_o       <= (state_d == RECV) || (state_d == WRITE);
`endif
      imem_we_o    <= (state_d == WRITE);
      start_o      <= (state_d == DONE);
      if (load_ok) err_o <= len_bad;
`ifdef IMEM_LOADER_CKSUM_EN
      else if (state_q == CKSUM && hs && lane3 && !sum_ok) err_o <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      part_q      <= '0;
      imem_addr_o <= '0;
      imem_data_o <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      if (load_ok) begin
        addr_q <= '0;
        idx_q  <= '0;
        len_q  <= len_i;
`ifdef IMEM_LOADER_CKSUM_EN
        sum_q  <= '0;
`endif
      end
      if (hs) begin
        idx_q <= idx_q + 2'd1;
        case (idx_q)
          2'd0:    part_q[7:0]   <= byte_data_i;
          2'd1:    part_q[15:8]  <= byte_data_i;
          2'd2:    part_q[23:16] <= byte_data_i;
          default: ;
        endcase
      end
      if (hs && lane3 && state_q == RECV) begin
        imem_addr_o <= addr_q[ADDR_W-1:0];
        imem_data_o <= word_in;
      end
      if (state_q == WRITE) begin
        addr_q <= addr_q + ONE;
`ifdef IMEM_LOADER_CKSUM_EN
        sum_q  <= sum_q + imem_data_o;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random byte streams against a word/queue model.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              load_i = 1'b0;
  logic [ADDR_W:0]   len_i = '0;
  logic              byte_valid_i = 1'b0;
  logic [7:0]        byte_data_i = '0;
  logic              byte_ready_o, imem_we_o, busy_o, start_o, err_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .load_i(load_i), .len_i(len_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
    .imem_data_o(imem_data_o), .busy_o(busy_o), .start_o(start_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] wr_log[$];
  int          wr_cnt = 0;
  bit          we_prev = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected writes: word k is bytes 4k..4k+3 little-endian, at address k.
  task automatic build_model(input int len, input bit add_ck);
    logic [31:0] w;
    logic [31:0] s;
    exp_q.delete();
    s = 0;
    for (int k = 0; k < len; k++) begin
      w = {tx_q[4*k+3], tx_q[4*k+2], tx_q[4*k+1], tx_q[4*k]};
      exp_q.push_back(w);
      s = s + w;
    end
`ifdef IMEM_LOADER_CKSUM_EN
    if (add_ck && len > 0)
      for (int b = 0; b < 4; b++) tx_q.push_back(s[8*b +: 8]);
`else
    if (add_ck && s === 32'hx) $display("unreachable");
`endif
  endtask

  always @(negedge clk) begin
    if (rst_i) begin
      chk("busy_start_excl", {31'd0, busy_o & start_o}, 32'd0);
      if (imem_we_o) begin
        chk("we_ready_low", {31'd0, byte_ready_o}, 32'd0);
        wr_log.push_back(imem_data_o);
        if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          chk("wr_addr", {24'd0, imem_addr_o}, {24'd0, wr_cnt[ADDR_W-1:0]});
          chk("wr_data", imem_data_o, exp_q.pop_front());
        end
        wr_cnt++;
      end
`ifndef IMEM_LOADER_CKSUM_EN
      if (we_prev && !imem_we_o && exp_q.size() == 0)
        chk("start_after_last_write", {31'd0, start_o}, 32'd1);
`endif
      we_prev = imem_we_o;
    end else begin
      we_prev = 0;
    end
  end

  task automatic start_load(input int len);
    wr_cnt = 0;
    wr_log.delete();
    @(negedge clk);
    load_i = 1'b1;
    len_i  = len[ADDR_W:0];
    @(negedge clk);
    load_i = 1'b0;
  endtask

  // gap_mode 0: always valid, 1: valid every other cycle, 2: random.
  task automatic send_all(input int gap_mode, input int ld_at);
    int  i = 0;
    int  guard = 0;
    bit  v;
    bit  ld_done = 0;
    while (i < tx_q.size() && guard < 20000) begin
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (guard % 2 == 0) : ($urandom_range(0, 2) != 0);
      byte_valid_i = v;
      byte_data_i  = tx_q[i];
      load_i = 1'b0;
      if (i == ld_at && !ld_done) begin
        load_i  = 1'b1;
        len_i   = 9'd3;
        ld_done = 1;
      end
      if (v && byte_ready_o) i++;
      @(negedge clk);
      guard++;
    end
    load_i = 1'b0;
    byte_valid_i = 1'b0;
    if (guard >= 20000) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!start_o && !err_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk(name, 32'd0, 32'd1);
  endtask

  task automatic run_load(input int len, input bit fill_rand, input int gap_mode, input int ld_at);
    if (fill_rand) begin
      tx_q.delete();
      for (int b = 0; b < 4 * len; b++) tx_q.push_back(8'($urandom_range(0, 255)));
    end
    build_model(len, 1'b1);
    start_load(len);
    chk("ready_after_load", {31'd0, byte_ready_o}, 32'd1);
    chk("busy_after_load", {31'd0, busy_o}, 32'd1);
    send_all(gap_mode, ld_at);
    wait_end("load_timeout");
    chk("start_done", {31'd0, start_o}, 32'd1);
    chk("err_done", {31'd0, err_o}, 32'd0);
    chk("busy_done", {31'd0, busy_o}, 32'd0);
    chk("write_count", wr_log.size(), len);
    chk("model_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("rst_we", {31'd0, imem_we_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_start", {31'd0, start_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_addr", {24'd0, imem_addr_o}, 32'd0);
    chk("rst_data", imem_data_o, 32'd0);
    rst_i = 1'b1;
    @(negedge clk);

    // Directed program load.
    tx_q = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h05, 8'h00, 8'h09, 8'h20};
    run_load(2, 1'b0, 0, -1);
    chk("lit_word0", wr_log[0], 32'h20080013);
    chk("lit_word1", wr_log[1], 32'h20090005);

    // Same load, valid toggling, plus a load pulse while busy that must be ignored.
    tx_q = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h05, 8'h00, 8'h09, 8'h20};
    run_load(2, 1'b0, 1, 3);
    chk("lit_toggle_word0", wr_log[0], 32'h20080013);
    chk("lit_toggle_word1", wr_log[1], 32'h20090005);

    // Zero-length load.
    exp_q.delete();
    start_load(0);
    chk("len0_start", {31'd0, start_o}, 32'd1);
    chk("len0_busy", {31'd0, busy_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("len0_nowrite", wr_log.size(), 32'd0);

    // Oversize length is rejected.
    start_load(257);
    chk("oversize_err", {31'd0, err_o}, 32'd1);
    chk("oversize_busy", {31'd0, busy_o}, 32'd0);
    chk("oversize_start", {31'd0, start_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("oversize_busy_later", {31'd0, busy_o}, 32'd0);
    chk("oversize_nowrite", wr_log.size(), 32'd0);

    // Reset in the middle of word 0.
    tx_q = '{8'h11, 8'h22};
    exp_q.delete();
    start_load(1);
    send_all(0, -1);
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, byte_ready_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_start", {31'd0, start_o}, 32'd0);
    chk("midrst_err", {31'd0, err_o}, 32'd0);
    chk("midrst_addr", {24'd0, imem_addr_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    tx_q = '{8'hef, 8'hbe, 8'had, 8'hde};
    run_load(1, 1'b0, 0, -1);
    chk("lit_after_rst", wr_log[0], 32'hdeadbeef);

    // Random loads with random source stalls.
    for (int r = 0; r < 8; r++)
      run_load($urandom_range(1, 12), 1'b1, 2, ($urandom_range(0, 1) == 1) ? 5 : -1);

    // Full-size load: addresses 0..255 with no wrap.
    run_load(256, 1'b1, 0, -1);
    chk("full_last_addr", {24'd0, imem_addr_o}, 32'd255);

`ifdef IMEM_LOADER_CKSUM_EN
    tx_q = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    build_model(1, 1'b0);
    start_load(1);
    send_all(0, -1);
    wait_end("ck_good_timeout");
    chk("ck_good_start", {31'd0, start_o}, 32'd1);
    chk("ck_good_err", {31'd0, err_o}, 32'd0);
    tx_q = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00};
    build_model(1, 1'b0);
    start_load(1);
    send_all(0, -1);
    wait_end("ck_bad_timeout");
    chk("ck_bad_err", {31'd0, err_o}, 32'd1);
    chk("ck_bad_start", {31'd0, start_o}, 32'd0);
    chk("ck_bad_written", wr_log.size(), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Synthesizable program loader for the pipelined CPU. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words sequentially into the instruction memory, then raises the CPU `start_i`. It performs in hardware the load-then-start sequence that simulation otherwise does with `$readmemb`.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width (256 words).
- `clk_i`  in  1  system clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `load_i`  in  1  one-cycle pulse that starts a load; sampled only in IDLE or DONE.
- `len_i`  in  ADDR_W+1  number of words to load; captured on the accepted `load_i`.
- `byte_valid_i`  in  1  source has a byte.
- `byte_data_i`  in  8  byte payload.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `imem_we_o`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr_o`  out  ADDR_W  word index being written.
- `imem_data_o`  out  32  assembled word.
- `busy_o`  out  1  load in progress.
- `start_o`  out  1  CPU start; drives `CPU.start_i`.
- `err_o`  out  1  load aborted or rejected; sticky until the next accepted `load_i`.

## Operation
- The FSM has four states.
  - IDLE: outputs are inactive. An accepted `load_i` behaves as follows:
    - `len_i` = 0 → go to DONE.
    - `len_i` > 2^ADDR_W → set `err_o` and stay in IDLE.
    - Otherwise clear the address, byte index and `err_o`, then go to RECV.
  - RECV: `byte_ready_o` = 1. On each handshake (`byte_valid_i` & `byte_ready_o`), store the byte into lane `byte_idx` (lane 0 = bits 7:0) and increment `byte_idx` mod 4. The handshake on lane 3 goes to WRITE.
  - WRITE: stays exactly one cycle with `imem_we_o` = 1 and `byte_ready_o` = 0.
    - Address +1.
    - If the words written equal `len` → go to CKSUM (if compiled) or DONE.
    - Else → go to RECV.
  - DONE: `start_o` = 1 and held; `busy_o` = 0. An accepted `load_i` clears `start_o` and restarts as in IDLE.
- `busy_o` = 1 in RECV, WRITE and CKSUM.
- `load_i` received while busy is ignored.
- `imem_addr_o` and `imem_data_o` hold their last values outside WRITE.
- The address counter is ADDR_W+1 bits wide internally. `imem_addr_o` is its low ADDR_W bits, so a full-size load (`len` = 2^ADDR_W) ends with the internal count at 2^ADDR_W and never wraps onto word 0.

## Timing
- Reset values: `byte_ready_o`, `imem_we_o`, `busy_o`, `start_o` and `err_o` are 0. `imem_addr_o` and `imem_data_o` are 0. The FSM is in IDLE.
- Reset asserted mid-load returns the block to IDLE immediately. A partial word is discarded and `start_o` drops.
- All outputs are registered.
- `byte_ready_o` rises the cycle after the accepted `load_i`.
- `imem_we_o` is high in the cycle following the lane-3 handshake. Peak throughput is 1 word per 5 cycles.
- `start_o` rises in the cycle after the final WRITE (or after the CKSUM compare). With `len` = 0 it rises the cycle after `load_i`.
- Source stalls (`byte_valid_i` = 0) simply hold state; there is no timeout.

## Configuration
- `IMEM_LOADER_CKSUM_EN` defined:
  - After the last WRITE, enter CKSUM and receive 4 more bytes (little-endian) with `byte_ready_o` = 1.
  - Compare them to the running sum of all written words mod 2^32.
  - Match → DONE.
  - Mismatch → set `err_o`, return to IDLE, and leave `start_o` at 0. The memory contents are left as written.
  - With `len` = 0 the checksum phase is skipped.
- `IMEM_LOADER_CKSUM_EN` undefined: there is no CKSUM state and no adder. `err_o` is set only by a length violation.

## Test plan
- Reset, `load_i` with `len` = 2, bytes 13 00 08 20 05 00 09 20 → writes 0x20080013 at 0 and 0x20090005 at 1. `start_o` rises 1 cycle after the second `imem_we_o`.
- Same load with `byte_valid_i` toggling every other cycle → identical writes. No byte is lost or duplicated, and `byte_ready_o` is 0 during each WRITE.
- `len` = 0 → no `imem_we_o`. `start_o` = 1 the cycle after `load_i`.
- `len` = 257 with ADDR_W = 8 → `err_o` = 1, `busy_o` stays 0, no write occurs.
- `rst_i` pulsed low after 2 bytes of word 0 → all outputs return to 0 at once. A fresh load then writes correctly starting from address 0.
- With `IMEM_LOADER_CKSUM_EN`, load `len` = 1 with word 0x00000005:
  - Checksum bytes 05 00 00 00 → `start_o` = 1.
  - Checksum bytes 06 00 00 00 → `err_o` = 1 and `start_o` stays 0.
